// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Define SEVSEG_LZB_EN to blank a leading zero on digit 3.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REFRESH_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_TC = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_TC   = BLINK_W'(BLINK_DIV - 1);
  localparam logic [REFRESH_W:0]   BLANK_LIM  = (REFRESH_W + 1)'(BLANK_CYCLES);

  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("sevenseg_scan_driver: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("sevenseg_scan_driver: BLANK_CYCLES must be in [0, REFRESH_DIV)");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("sevenseg_scan_driver: BLINK_DIV must be >= 1");
  end

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           digit_idx;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [3:0][3:0]      snap_num;
  logic [3:0]           snap_blink;
  logic [3:0]           snap_dp;

  logic       refresh_tc;
  logic       blink_tc;
  logic [3:0] cur_digit;
  logic       suppress;
  logic       blank_lzb;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  assign refresh_tc = (refresh_cnt == REFRESH_TC);
  assign blink_tc   = (blink_cnt == BLINK_TC);

  // Inputs are captured only at the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      snap_num    <= '0;
      snap_blink  <= 4'h0;
      snap_dp     <= 4'h0;
    end else begin
      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + REFRESH_W'(1);
      if (refresh_tc) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (refresh_tc && digit_idx == 2'd3) begin
        snap_num   <= {num3, num2, num1, num0};
        snap_blink <= blink_mask;
        snap_dp    <= dp_sel;
      end
      blink_cnt <= blink_tc ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_tc) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  always_comb begin
    cur_digit = snap_num[digit_idx];
    suppress  = snap_blink[digit_idx] && !blink_phase;
    blank_lzb = 1'b0;
`ifdef SEVSEG_LZB_EN
    blank_lzb = (digit_idx == 2'd3) && (snap_num[3] == 4'd0);
`endif
    an_d  = ({1'b0, refresh_cnt} < BLANK_LIM) ? 4'hF : ~(4'b0001 << digit_idx);
    seg_d = (suppress || blank_lzb) ? 7'h7F : decode(cur_digit);
    dp_d  = ~(snap_dp[digit_idx] && !suppress);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver: per-frame table of inputs and hand-decoded expected outputs.
module tb_sevenseg_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] num0, num1, num2, num3;
  logic [3:0] blink_mask, dp_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] D3_ZERO = 7'h7F;
`else
  localparam logic [6:0] D3_ZERO = 7'h40;
`endif

  // Inputs are applied early in a frame and shown in the next one; seg/dp expectations are for this frame.
  typedef struct {
    logic [15:0]     nums;
    logic [3:0]      blink;
    logic [3:0]      dpsel;
    logic [3:0][6:0] seg_exp;
    logic [3:0]      dp_exp;
  } frame_t;

  frame_t frames [9];

  sevenseg_scan_driver #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1),
    .BLINK_DIV   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .num0      (num0),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .blink_mask(blink_mask),
    .dp_sel    (dp_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " an"}, {3'b0, an}, 7'h0F);
    chk({tag, " seg"}, seg, 7'h7F);
    chk({tag, " dp"}, {6'b0, dp}, 7'h01);
  endtask

  initial begin
    logic [3:0] an_exp;
    int slot;

    frames[0] = '{16'h1234, 4'h0, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    frames[1] = '{16'h1237, 4'h3, 4'h4, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    frames[2] = '{16'h1237, 4'h3, 4'h4, {7'h79, 7'h24, 7'h30, 7'h78}, 4'b1011};
    frames[3] = '{16'h12B7, 4'h1, 4'h3, {7'h79, 7'h24, 7'h7F, 7'h7F}, 4'b1011};
    frames[4] = '{16'h12B7, 4'h1, 4'h3, {7'h79, 7'h24, 7'h7F, 7'h78}, 4'b1100};
    frames[5] = '{16'h0958, 4'h0, 4'h4, {7'h79, 7'h24, 7'h7F, 7'h7F}, 4'b1101};
    frames[6] = '{16'h0060, 4'h8, 4'h8, {D3_ZERO, 7'h10, 7'h12, 7'h00}, 4'b1011};
    frames[7] = '{16'h0060, 4'h8, 4'h8, {7'h7F, 7'h40, 7'h02, 7'h40}, 4'b1111};
    frames[8] = '{16'h0060, 4'h8, 4'h8, {D3_ZERO, 7'h40, 7'h02, 7'h40}, 4'b0111};

    reset = 1'b1;
    {num3, num2, num1, num0} = 16'h0000;
    blink_mask = 4'h0;
    dp_sel     = 4'h0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_vals($sformatf("reset edge %0d", i));
    end
    reset = 1'b0;
    chk_reset_vals("at release");

    for (int f = 0; f < 9; f++) begin
      for (int j = 0; j < 16; j++) begin
        step();
        slot   = j / 4;
        an_exp = (j % 4 == 0) ? 4'hF : ~(4'b0001 << slot);
        chk($sformatf("f%0d e%0d an", f, j), {3'b0, an}, {3'b0, an_exp});
        chk($sformatf("f%0d e%0d seg", f, j), seg, frames[f].seg_exp[slot]);
        chk($sformatf("f%0d e%0d dp", f, j), {6'b0, dp}, {6'b0, frames[f].dp_exp[slot]});
        if (j == 1) begin
          {num3, num2, num1, num0} = frames[f].nums;
          blink_mask = frames[f].blink;
          dp_sel     = frames[f].dpsel;
        end
      end
    end

    // Mid-slot reset: outputs clear on the next edge, then the scan restarts at digit 0 with a cleared snapshot.
    for (int j = 0; j < 6; j++) step();
    reset = 1'b1;
    step();
    chk_reset_vals("mid reset edge");
    step();
    reset = 1'b0;
    chk_reset_vals("after mid reset");
    for (int j = 0; j < 8; j++) begin
      step();
      slot   = j / 4;
      an_exp = (j % 4 == 0) ? 4'hF : ~(4'b0001 << slot);
      chk($sformatf("restart e%0d an", j), {3'b0, an}, {3'b0, an_exp});
      chk($sformatf("restart e%0d seg", j), seg, 7'h40);
      chk($sformatf("restart e%0d dp", j), {6'b0, dp}, 7'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Downstream of the time-of-day counter. Consumes its four BCD digits (num0 = minutes ones, num1 = minutes tens, num2 = hours ones, num3 = hours tens).
- Drives the board's 4-digit common-anode seven-segment display by time-multiplexing the digits.
- Supports frame-coherent digit snapshots, per-digit blinking for time-set mode, anti-ghost blanking, and a decimal point/colon.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); must be >= 2
BLANK_CYCLES, 500, cycles at start of each slot with all anodes off; must be < REFRESH_DIV
BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); must be >= 1

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
num0  input  4  BCD digit 0 (rightmost)
num1  input  4  BCD digit 1
num2  input  4  BCD digit 2
num3  input  4  BCD digit 3 (leftmost)
blink_mask  input  4  bit i set -> digit i blinks
dp_sel  input  4  bit i set -> decimal point of digit i lit
an  output  4  anode enables, active-low, bit i = digit i
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on posedge clk. All outputs are registered.
- Reset values: an=4'b1111, seg=7'h7F, dp=1. refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=1 (visible). Snapshot registers = 0.
- Reset mid-frame: all counters and outputs return to their reset values on the next edge. There is no partial-state retention.
- refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap (terminal count), digit_idx advances 0->1->2->3->0.
- Snapshot: on the cycle where refresh_cnt is terminal and digit_idx==3, latch num0..num3, blink_mask and dp_sel. Input changes inside a frame are invisible until the next frame (no tearing).
  - First snapshot: taken at the end of the first frame after reset. The first frame displays zeros.
- Blink: blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase at its terminal count. It is free-running and independent of the scan.
- Output register, updated every cycle from the current refresh_cnt and digit_idx (1-cycle latency):
  - an: all ones if refresh_cnt < BLANK_CYCLES; otherwise only bit digit_idx is low.
  - seg: decode of the snapshot digit selected by digit_idx.
  - dp: low iff snapshot dp_sel[digit_idx] is set and the digit is not blink-suppressed.
- Blink suppression: if snapshot blink_mask[digit_idx]=1 and blink_phase=0, then seg=7'h7F and dp=1. The anode is still driven per the an rule above.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10-15: seg=7'h7F (blank); dp still honoured.
- Simultaneous events: a snapshot and a blink toggle in the same cycle are both applied. The output register uses pre-edge values, so new data appears one cycle later.
- Invalid parameters: trigger an elaboration-time $error.

Optional Feature:
- Macro: SEVSEG_LZB_EN (leading-zero blanking).
- Defined: if snapshot num3==0, digit 3 shows seg=7'h7F. The anode is still enabled per the an rule and dp still follows dp_sel[3]. Example: 09:30 displays " 9:30".
- Undefined: digit 3 always decodes normally, so 0 shows as "0".

Test Plan:
- Parameters for all scenarios: REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_DIV=16.
1. Hold reset 3 cycles -> an=1111, seg=7F, dp=1 during reset and on the cycle after release. The first frame (16 cycles) shows digit 0 decode (seg=1000000) on every slot.
2. Apply num3..0=1,2,3,4 before the first snapshot -> second frame: an sequence 1110,1101,1011,0111 with seg 0011001, 0110000, 0100100, 1111001. an=1111 on the first cycle of each slot.
3. Change num0 from 4 to 7 mid-frame -> seg for digit 0 remains 0011001 until the next snapshot, then becomes 1111000.
4. blink_mask=4'b0011, dp_sel=4'b0100 -> digits 0 and 1 alternate between decode and 7F every 16 cycles. Digit 2 dp=0 constantly. Digits 2 and 3 never blank.
5. num1=4'hB -> digit 1 seg=7F while the other digits decode normally. Assert reset mid-slot -> outputs return to reset values on the next edge and the scan restarts at digit 0.
6. num3=0 with SEVSEG_LZB_EN defined -> digit 3 slot shows an=0111, seg=7F. Same stimulus without the macro -> seg=1000000.
